ibus_fetch_bridge: RTL

Parametrised instruction-bus bridge between the core fetch port (decoupled req/resp) and an in-order, fixed-or-variable-latency instruction memory port that applies no backpressure. It bounds outstanding fetches by credit, buffers returned words in a response FIFO, and supports a fetch flush (redirect) that discards buffered and still-in-flight responses. It replaces the single-beat pass-through bridge as the fetch-side adapter for synthesis and simulation.

---
 rtl/ibus_fetch_bridge.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ibus_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ibus_fetch_bridge
// Brief    : Credit-bounded fetch bridge with response FIFO, optional bypass
//            and flush that discards buffered and in-flight words.
// Revision : 1.0
// ============================================================================
module ibus_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_bus_req_valid,
  output logic              io_bus_req_ready,
  input  logic [ADDR_W-1:0] io_bus_req_bits,
  output logic              io_bus_resp_valid,
  input  logic              io_bus_resp_ready,
  output logic [DATA_W-1:0] io_bus_resp_bits,
  output logic              io_bus_resp_err,
  input  logic              io_flush,
  output logic              io_mem_req_valid,
  output logic [ADDR_W-1:0] io_mem_req_addr,
  input  logic              io_mem_rsp_valid,
  input  logic [DATA_W-1:0] io_mem_rsp_data,
  input  logic              io_mem_rsp_err
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_sum_w = c_cnt_w + 2;
  localparam logic [c_sum_w-1:0] c_depth    = c_sum_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

  logic [c_cnt_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic               r_err  [DEPTH];

  logic [c_sum_w-1:0] w_sum;
  logic               w_fire;
  logic               w_drop_any;
  logic               w_rsp_live;
  logic               w_nonempty;
  logic               w_bypass;
  logic               w_pop;
  logic               w_push;
  logic [c_cnt_w-1:0] w_pend;
  logic [c_cnt_w-1:0] w_inflight_nxt;
  logic [c_cnt_w-1:0] w_drop_nxt;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Credits cover issued-but-live, to-be-dropped and buffered words together.
  assign w_sum            = c_sum_w'(r_inflight) + c_sum_w'(r_drop_cnt) + c_sum_w'(r_count);
  assign io_bus_req_ready = !io_flush && (w_sum < c_depth);
  assign w_fire           = io_bus_req_valid && io_bus_req_ready;
  assign io_mem_req_valid = w_fire;
  assign io_mem_req_addr  = io_bus_req_bits;

  assign w_drop_any        = (r_drop_cnt != '0);
  assign w_rsp_live        = io_mem_rsp_valid && !w_drop_any && !io_flush;
  assign w_nonempty        = (r_count != '0);
  assign w_bypass          = (BYPASS != 0) && !w_nonempty && w_rsp_live;
  assign io_bus_resp_valid = w_nonempty || w_bypass;
  assign w_pop             = w_nonempty && io_bus_resp_ready;
  assign w_push            = w_rsp_live && !(w_bypass && io_bus_resp_ready);
  assign w_pend            = r_drop_cnt + r_inflight;

  always_comb begin
    io_bus_resp_bits = '0;
    io_bus_resp_err  = 1'b0;
    if (w_nonempty) begin
      io_bus_resp_bits = r_data[r_rd_ptr];
      io_bus_resp_err  = r_err[r_rd_ptr];
    end else if (w_bypass) begin
      io_bus_resp_bits = io_mem_rsp_data;
      io_bus_resp_err  = io_mem_rsp_err;
    end
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    w_drop_nxt     = r_drop_cnt;
    if (io_flush) begin
      // Everything live becomes stale; the response arriving now is one of them.
      w_inflight_nxt = '0;
      w_drop_nxt     = (io_mem_rsp_valid && (w_pend != '0)) ? w_pend - c_cnt_w'(1) : w_pend;
    end else begin
      if (io_mem_rsp_valid && w_drop_any) begin
        w_drop_nxt = r_drop_cnt - c_cnt_w'(1);
      end
      if (w_fire && !(w_rsp_live && (r_inflight != '0))) begin
        w_inflight_nxt = r_inflight + c_cnt_w'(1);
      end else if (!w_fire && w_rsp_live && (r_inflight != '0)) begin
        w_inflight_nxt = r_inflight - c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (io_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      end
    end
  end

  // Storage needs no reset: the head is only exposed while count is nonzero.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= io_mem_rsp_data;
      r_err[r_wr_ptr]  <= io_mem_rsp_err;
    end
  end

endmodule
`default_nettype wire
